// File: rtl/servisia_gpio_if.sv
// Wishbone classic slave bus for servisia_gpio; carries the request and response signals.
//
// Handshake: the master raises wb_stb_i and holds it, together with wb_adr_i,
// wb_we_i and wb_dat_i, until it sees wb_ack_o = 1. The slave registers wb_ack_o:
// ack rises on the edge after a cycle with stb = 1 and ack = 0, and stays high for
// exactly one cycle. A stb that is still high in the ack cycle does not start a new
// transfer until the following cycle. wb_rdt_o is meaningful only while wb_ack_o = 1.
interface servisia_gpio_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       wb_adr_i;
  logic [WIDTH-1:0] wb_dat_i;
  logic             wb_we_i;
  logic             wb_stb_i;
  logic [WIDTH-1:0] wb_rdt_o;
  logic             wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i,
    input  wb_rdt_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i,
    output wb_rdt_o, wb_ack_o
  );
endinterface

// File: rtl/servisia_gpio.sv
// servisia_gpio: Wishbone GPIO with per-pin direction, synchronised inputs,
// atomic SET/CLR writes and optional edge interrupts.
// Optional feature macro: SERVISIA_GPIO_IRQ_EN (edge detect, IRQ_EN/EDGE/STATUS, irq_o).
// Without it registers 5-7 read 0, ignore writes, and irq_o is tied low.
module servisia_gpio #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  servisia_gpio_if.slave       wb,
  input  logic [WIDTH-1:0]     gpio_i,
  output logic [WIDTH-1:0]     gpio_o,
  output logic [WIDTH-1:0]     gpio_oe_o,
  output logic                 irq_o
);
  localparam logic [2:0] ADR_DATA_OUT = 3'd0;
  localparam logic [2:0] ADR_DIR      = 3'd1;
  localparam logic [2:0] ADR_DATA_IN  = 3'd2;
  localparam logic [2:0] ADR_SET      = 3'd3;
  localparam logic [2:0] ADR_CLR      = 3'd4;
  localparam logic [2:0] ADR_IRQ_EN   = 3'd5;
  localparam logic [2:0] ADR_IRQ_EDGE = 3'd6;
  localparam logic [2:0] ADR_IRQ_STAT = 3'd7;

  // A transfer is accepted in any cycle with stb high and no ack outstanding.
  logic access;
  logic wr_en;
  logic rd_en;
  assign access = wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr_en  = access & wb.wb_we_i;
  assign rd_en  = access & ~wb.wb_we_i;

  logic             ack_q;
  logic [WIDTH-1:0] rdt_q;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] irq_en_rd;
  logic [WIDTH-1:0] irq_edge_rd;
  logic [WIDTH-1:0] irq_stat_rd;

  assign data_in       = sync_q[SYNC_STAGES-1];
  assign gpio_o        = data_out;
  assign gpio_oe_o     = dir;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_rdt_o   = rdt_q;

  // Register read multiplexer; write-only and unused slots read as zero.
  always_comb begin
    rd_val = '0;
    case (wb.wb_adr_i)
      ADR_DATA_OUT: rd_val = data_out;
      ADR_DIR:      rd_val = dir;
      ADR_DATA_IN:  rd_val = data_in;
      ADR_SET:      rd_val = '0;
      ADR_CLR:      rd_val = '0;
      ADR_IRQ_EN:   rd_val = irq_en_rd;
      ADR_IRQ_EDGE: rd_val = irq_edge_rd;
      ADR_IRQ_STAT: rd_val = irq_stat_rd;
      default:      rd_val = '0;
    endcase
  end

  // Registered acknowledge and read data; read data is zero outside read acks.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= access;
      rdt_q <= rd_en ? rd_val : '0;
    end
  end

  // Output data and direction; SET/CLR give atomic bit updates.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
    end else if (wr_en) begin
      case (wb.wb_adr_i)
        ADR_DATA_OUT: data_out <= wb.wb_dat_i;
        ADR_DIR:      dir      <= wb.wb_dat_i;
        ADR_SET:      data_out <= data_out | wb.wb_dat_i;
        ADR_CLR:      data_out <= data_out & ~wb.wb_dat_i;
        default:      ;
      endcase
    end
  end

  // Pad input synchroniser chain, sampled regardless of pin direction.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef SERVISIA_GPIO_IRQ_EN
  // The arm counter keeps the reset-cleared prev sample from looking like an edge
  // while the synchroniser fills with pins that were already high.
  localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_edge;
  logic [WIDTH-1:0] irq_status;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] event_v;
  logic [WIDTH-1:0] w1c;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic             irq_q;

  assign armed       = (arm_cnt == ARM_DONE);
  assign irq_en_rd   = irq_en;
  assign irq_edge_rd = irq_edge;
  assign irq_stat_rd = irq_status;
  assign irq_o       = irq_q;

  // Per-pin events for the selected polarity, and the write-one-to-clear mask.
  always_comb begin
    event_v = '0;
    w1c     = '0;
    if (armed)
      event_v = (data_in & ~prev_q & irq_edge) | (~data_in & prev_q & ~irq_edge);
    if (wr_en && (wb.wb_adr_i == ADR_IRQ_STAT))
      w1c = wb.wb_dat_i;
  end

  // Interrupt configuration, sticky status (set beats clear) and registered irq.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en     <= '0;
      irq_edge   <= '0;
      irq_status <= '0;
      prev_q     <= '0;
      arm_cnt    <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q <= data_in;
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
      if (wr_en && (wb.wb_adr_i == ADR_IRQ_EN))   irq_en   <= wb.wb_dat_i;
      if (wr_en && (wb.wb_adr_i == ADR_IRQ_EDGE)) irq_edge <= wb.wb_dat_i;
      irq_status <= (irq_status & ~w1c) | event_v;
      irq_q      <= |(irq_status & irq_en);
    end
  end
`else
  assign irq_en_rd   = '0;
  assign irq_edge_rd = '0;
  assign irq_stat_rd = '0;
  assign irq_o       = 1'b0;
`endif
endmodule
